// File: rtl/fetch_queue_if.sv
// Fetch queue bundle: redirect, imem request/response, decode handshake.
// master = fetch_queue side, slave = surrounding pipeline/memory side.
interface fetch_queue_if;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_inst;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        input  flush,
        input  redirect_pc,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_inst,
        input  out_ready,
        output imem_req_valid,
        output imem_req_addr,
        output out_valid,
        output out_inst,
        output out_pc
    );

    modport slave (
        output flush,
        output redirect_pc,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_inst,
        output out_ready,
        input  imem_req_valid,
        input  imem_req_addr,
        input  out_valid,
        input  out_inst,
        input  out_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch PC owner + in-order {pc,inst} queue feeding decode.
// Optional FQ_BYPASS_EN: empty-queue response goes straight to decode.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst_n,
    fetch_queue_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic          drop;

    logic [AW+1:0] used;
    logic          credit;
    logic          accept;
    logic          rsp_ok;
    logic          byp;
    logic          push;
    logic          pop;

    // Credit counts the in-flight word so a full queue never gets a push.
    assign used   = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
    assign credit = used < (AW+2)'(DEPTH);

    assign bus.imem_req_valid = rst_n & ~bus.flush & credit;
    assign bus.imem_req_addr  = fetch_pc;

    assign accept = bus.imem_req_valid & bus.imem_req_ready;
    assign rsp_ok = bus.imem_rsp_valid & inflight & ~drop;

`ifdef FQ_BYPASS_EN
    assign byp = rsp_ok & (count == '0);
`else
    assign byp = 1'b0;
`endif

    assign bus.out_valid = (count != '0) | byp;
    assign bus.out_inst  = byp ? bus.imem_rsp_inst : mem[rd_ptr].inst;
    assign bus.out_pc    = byp ? req_pc : mem[rd_ptr].pc;

    assign pop  = (count != '0) & bus.out_ready & ~bus.flush;
    assign push = rsp_ok & ~bus.flush & ~(byp & bus.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= PC_RESET;
            req_pc   <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            drop     <= inflight | accept;
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
            drop     <= 1'b0;
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
            if (push) begin
                mem[wr_ptr] <= '{pc: req_pc, inst: bus.imem_rsp_inst};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
